// File: rtl/led_uart_tx.sv
// 8N1 UART serialiser behind a one-deep holding register.
// The holding register lets the next byte wait so back-to-back frames leave no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | start bit (line low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); chains straight into START if a byte is waiting
module led_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iData,
   input  logic       iValid,
   output logic       oReady,
   output logic       oTx,
   output logic       oBusy
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic [2:0]    bitIdx;
   logic [7:0]    shiftReg;
   logic [7:0]    holdData;
   logic          holdFull;
   logic          accept;
   logic          timerDone;
   logic          load;

   assign accept    = iValid && oReady;
   assign timerDone = (timer == TLAST);
   // The holding register drains either from IDLE or exactly at stop-bit expiry.
   assign load      = holdFull && ((state == IDLE) || ((state == STOP) && timerDone));
   assign oBusy     = (state != IDLE);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         holdFull <= 1'b0;
         holdData <= 8'h00;
         oReady   <= 1'b1;
      end else if (accept) begin
         holdFull <= 1'b1;
         holdData <= iData;
         oReady   <= 1'b0;
      end else if (load) begin
         holdFull <= 1'b0;
         oReady   <= 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         timer    <= '0;
         bitIdx   <= 3'd0;
         shiftReg <= 8'h00;
         oTx      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (holdFull) begin
                  state    <= START;
                  shiftReg <= holdData;
                  timer    <= '0;
                  oTx      <= 1'b0;
               end
            end
            START: begin
               if (timerDone) begin
                  state  <= DATA;
                  timer  <= '0;
                  bitIdx <= 3'd0;
                  oTx    <= shiftReg[0];
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DATA: begin
               if (timerDone) begin
                  timer <= '0;
                  if (bitIdx == 3'd7) begin
                     state <= STOP;
                     oTx   <= 1'b1;
                  end else begin
                     bitIdx   <= bitIdx + 3'd1;
                     shiftReg <= {1'b0, shiftReg[7:1]};
                     oTx      <= shiftReg[1];
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            STOP: begin
               if (timerDone) begin
                  timer <= '0;
                  if (holdFull) begin
                     state    <= START;
                     shiftReg <= holdData;
                     oTx      <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               oTx   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_uart_tx.sv
// Bench for led_uart_tx: per-cycle comparison against a queue-based line model,
// plus a line receiver that decodes the DUT's serial output into bytes.
module tb_led_uart_tx;

   localparam int CPB = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] iData = 8'h00;
   logic       iValid = 1'b0;
   logic       oReady;
   logic       oTx;
   logic       oBusy;

   int errors = 0;
   int checks = 0;

   led_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .iData (iData),
      .iValid(iValid),
      .oReady(oReady),
      .oTx   (oTx),
      .oBusy (oBusy)
   );

   always #5 Clock = ~Clock;

   // Reference model: a frame becomes a list of line samples; the line shows
   // one sample per cycle and a waiting byte is framed as soon as the list runs dry.
   bit         mHoldFull = 1'b0;
   logic [7:0] mHoldByte = 8'h00;
   bit         mLine[$];
   logic [7:0] sentQ[$];
   bit         mAcc = 1'b0;
   logic       eTx = 1'b1;
   logic       eBusy = 1'b0;
   logic       eReady = 1'b1;

   always @(posedge Clock or negedge Reset) begin
      logic [9:0] fr;
      if (!Reset) begin
         mHoldFull = 1'b0;
         mLine.delete();
         mAcc   = 1'b0;
         eTx    = 1'b1;
         eBusy  = 1'b0;
         eReady = 1'b1;
      end else begin
         mAcc = iValid && eReady;
         if (mLine.size() == 0 && mHoldFull) begin
            fr = {1'b1, mHoldByte, 1'b0};
            for (int i = 0; i < 10; i++)
               for (int j = 0; j < CPB; j++) mLine.push_back(fr[i]);
            sentQ.push_back(mHoldByte);
            mHoldFull = 1'b0;
         end
         if (mAcc) begin
            mHoldFull = 1'b1;
            mHoldByte = iData;
         end
         if (mLine.size() > 0) begin
            eTx   = mLine.pop_front();
            eBusy = 1'b1;
         end else begin
            eTx   = 1'b1;
            eBusy = 1'b0;
         end
         eReady = !mHoldFull;
      end
   end

   // Line receiver: samples each bit in its middle cycle.
   bit         rxOn = 1'b0;
   int         rxCnt = 0;
   logic [7:0] rxSh = 8'h00;
   logic [7:0] rxQ[$];

   always @(negedge Clock or negedge Reset) begin
      if (!Reset) begin
         rxOn = 1'b0;
      end else if (!rxOn) begin
         if (oTx === 1'b0) begin
            rxOn  = 1'b1;
            rxCnt = 0;
         end
      end else begin
         rxCnt++;
         if ((rxCnt % CPB) == CPB / 2 && rxCnt / CPB >= 1 && rxCnt / CPB <= 8)
            rxSh[rxCnt / CPB - 1] = oTx;
         if (rxCnt == 9 * CPB + CPB / 2) begin
            rxQ.push_back(rxSh);
            rxOn = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      #1;
      checks++;
      if (oTx !== 1'b1 || oBusy !== 1'b0 || oReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_assert tx=%b busy=%b ready=%b required 1 0 1", oTx, oBusy, oReady);
      end
      repeat (3) tick();
      Reset = 1'b1;
      for (int c = 0; c < 50; c++) begin
         tick();
         checks++;
         if (oTx !== 1'b1 || oBusy !== 1'b0 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d tx=%b busy=%b ready=%b required 1 0 1", c, oTx, oBusy, oReady);
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] b;
      logic [9:0] fr;
      b  = 8'hA5;
      fr = {1'b1, b, 1'b0};
      rxQ.delete();
      iData  = b;
      iValid = 1'b1;
      tick();
      iValid = 1'b0;
      checks++;
      if (oTx !== 1'b1 || oReady !== 1'b0 || oBusy !== 1'b0) begin
         errors++;
         $display("FAIL single_accept tx=%b ready=%b busy=%b required 1 0 0", oTx, oReady, oBusy);
      end
      for (int k = 0; k < 10 * CPB; k++) begin
         tick();
         checks++;
         if (oTx !== fr[k / CPB] || oBusy !== 1'b1 || oTx !== eTx || oReady !== eReady) begin
            errors++;
            $display("FAIL single_frame cyc=%0d tx=%b busy=%b ready=%b required tx=%b busy=1 ready=%b",
                     k, oTx, oBusy, oReady, fr[k / CPB], eReady);
         end
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (oTx !== 1'b1 || oBusy !== 1'b0 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL single_after cyc=%0d tx=%b busy=%b ready=%b required 1 0 1", k, oTx, oBusy, oReady);
         end
      end
      checks++;
      if (rxQ.size() != 1 || rxQ[0] !== b) begin
         errors++;
         $display("FAIL single_rx got %0d bytes first=%h required 1 byte a5", rxQ.size(),
                  (rxQ.size() > 0) ? rxQ[0] : 8'hxx);
      end
   endtask

   task automatic test_back_to_back();
      int idx;
      int run;
      int runs;
      int maxRun;
      logic [7:0] bl[2];
      bl[0] = 8'h01;
      bl[1] = 8'h80;
      idx = 0; run = 0; runs = 0; maxRun = 0;
      rxQ.delete();
      iData  = bl[0];
      iValid = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         checks++;
         if (oTx !== eTx || oBusy !== eBusy || oReady !== eReady) begin
            errors++;
            $display("FAIL b2b_cycle cyc=%0d tx=%b/%b busy=%b/%b ready=%b/%b (got/required)",
                     c, oTx, eTx, oBusy, eBusy, oReady, eReady);
         end
         if (oBusy === 1'b1) run++;
         else if (run > 0) begin
            runs++;
            if (run > maxRun) maxRun = run;
            run = 0;
         end
         if (mAcc && iValid) begin
            idx++;
            if (idx < 2) iData = bl[idx];
            else iValid = 1'b0;
         end
      end
      checks++;
      if (runs != 1 || maxRun != 80) begin
         errors++;
         $display("FAIL b2b_busy runs=%0d longest=%0d required 1 run of 80", runs, maxRun);
      end
      checks++;
      if (rxQ.size() != 2 || rxQ[0] !== bl[0] || rxQ[1] !== bl[1]) begin
         errors++;
         $display("FAIL b2b_rx got %0d bytes required 01 80", rxQ.size());
      end
   endtask

   task automatic test_backpressure();
      int idx;
      int lowCnt;
      logic [7:0] bl[3];
      bl[0] = 8'h11;
      bl[1] = 8'h22;
      bl[2] = 8'h33;
      idx = 0; lowCnt = 0;
      rxQ.delete();
      iData  = bl[0];
      iValid = 1'b1;
      for (int c = 0; c < 140; c++) begin
         tick();
         checks++;
         if (oTx !== eTx || oBusy !== eBusy || oReady !== eReady) begin
            errors++;
            $display("FAIL bp_cycle cyc=%0d tx=%b/%b busy=%b/%b ready=%b/%b (got/required)",
                     c, oTx, eTx, oBusy, eBusy, oReady, eReady);
         end
         if (oReady === 1'b0) lowCnt++;
         if (mAcc && iValid) begin
            idx++;
            if (idx < 3) iData = bl[idx];
            else iValid = 1'b0;
         end
      end
      // 1 cycle after the first accept, then 39 per byte waiting behind a frame
      checks++;
      if (lowCnt != 79) begin
         errors++;
         $display("FAIL bp_ready_low cycles=%0d required 79", lowCnt);
      end
      checks++;
      if (rxQ.size() != 3 || rxQ[0] !== bl[0] || rxQ[1] !== bl[1] || rxQ[2] !== bl[2]) begin
         errors++;
         $display("FAIL bp_rx got %0d bytes required 11 22 33 in order", rxQ.size());
      end
   endtask

   task automatic test_reset_mid();
      rxQ.delete();
      iData  = 8'hFF;
      iValid = 1'b1;
      tick();
      iValid = 1'b0;
      tick();
      iData  = 8'h0F;
      iValid = 1'b1;
      tick();
      iValid = 1'b0;
      repeat (16) tick();
      checks++;
      if (oBusy !== 1'b1 || oReady !== 1'b0) begin
         errors++;
         $display("FAIL mid_prereset busy=%b ready=%b required 1 0", oBusy, oReady);
      end
      #2;
      Reset = 1'b0;
      #1;
      checks++;
      if (oTx !== 1'b1 || oBusy !== 1'b0 || oReady !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset tx=%b busy=%b ready=%b required 1 0 1", oTx, oBusy, oReady);
      end
      repeat (2) tick();
      Reset = 1'b1;
      for (int c = 0; c < 60; c++) begin
         tick();
         checks++;
         if (oTx !== 1'b1 || oBusy !== 1'b0 || oBusy !== eBusy || oReady !== eReady) begin
            errors++;
            $display("FAIL mid_after cyc=%0d tx=%b busy=%b ready=%b required 1 0 %b", c, oTx, oBusy, oReady, eReady);
         end
      end
      checks++;
      if (rxQ.size() != 0) begin
         errors++;
         $display("FAIL mid_rx got %0d bytes required 0", rxQ.size());
      end
   endtask

   task automatic test_ignored();
      rxQ.delete();
      iData  = 8'h3C;
      iValid = 1'b1;
      tick();
      checks++;
      if (oReady !== 1'b0 || eReady !== 1'b0) begin
         errors++;
         $display("FAIL ign_ready ready=%b required 0", oReady);
      end
      iData = 8'h5A;
      tick();
      iValid = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         checks++;
         if (oTx !== eTx || oBusy !== eBusy || oReady !== eReady) begin
            errors++;
            $display("FAIL ign_cycle cyc=%0d tx=%b/%b busy=%b/%b ready=%b/%b (got/required)",
                     c, oTx, eTx, oBusy, eBusy, oReady, eReady);
         end
      end
      checks++;
      if (rxQ.size() != 1 || rxQ[0] !== 8'h3C) begin
         errors++;
         $display("FAIL ign_rx got %0d bytes first=%h required only 3c", rxQ.size(),
                  (rxQ.size() > 0) ? rxQ[0] : 8'hxx);
      end
   endtask

   task automatic test_random();
      rxQ.delete();
      sentQ.delete();
      for (int c = 0; c < 600; c++) begin
         iValid = ($urandom_range(0, 3) == 0);
         iData  = 8'($urandom);
         tick();
         checks++;
         if (oTx !== eTx || oBusy !== eBusy || oReady !== eReady) begin
            errors++;
            $display("FAIL rand_cycle cyc=%0d tx=%b/%b busy=%b/%b ready=%b/%b (got/required)",
                     c, oTx, eTx, oBusy, eBusy, oReady, eReady);
         end
      end
      iValid = 1'b0;
      repeat (90) tick();
      checks++;
      if (rxQ.size() != sentQ.size() || sentQ.size() == 0) begin
         errors++;
         $display("FAIL rand_count got %0d bytes required %0d", rxQ.size(), sentQ.size());
      end else begin
         for (int i = 0; i < sentQ.size(); i++) begin
            checks++;
            if (rxQ[i] !== sentQ[i]) begin
               errors++;
               $display("FAIL rand_byte idx=%0d got %h required %h", i, rxQ[i], sentQ[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_ignored();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_uart_tx.md
LED_UART_TX -- requirements
Module: led_uart_tx

Downstream stage of the LED output register. It serialises each accepted 8-bit value onto an 8N1 UART line.

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning Clock cycles per UART bit (50 MHz / 115200); legal values >= 2.
REQ-002 SHALL have port Clock, input, 1 bit, the single clock; all state updates on posedge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port iData, input, 8 bits: byte to transmit, sampled only on accept.
REQ-005 SHALL have port iValid, input, 1 bit: iData holds a byte to send.
REQ-006 SHALL have port oReady, output, 1 bit: holding register empty, so a byte can be accepted.
REQ-007 SHALL have port oTx, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port oBusy, output, 1 bit: frame in progress (state != IDLE).

Function
REQ-009 SHALL accept a byte on a posedge where iValid=1 and oReady=1, storing iData in a 1-deep holding register.
REQ-010 SHALL ignore iValid while oReady=0: no state change, iData not sampled.
REQ-011 SHALL register oReady: oReady=0 on the cycle after accept, and 1 again on the cycle after the holding register is emptied.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL transition IDLE->START on the first posedge where the holding register is full, moving it into the shift register and marking it empty on that same edge.
REQ-014 SHALL hold START, each DATA bit and STOP for exactly CLKS_PER_BIT cycles, counted by a bit-timer running 0..CLKS_PER_BIT-1.
REQ-015 SHALL drive oTx=0 in START, then data bits LSB first in DATA, then oTx=1 in STOP.
REQ-016 SHALL move START->DATA after timer expiry, and DATA->STOP after bit index 7 expires (3-bit bit index, 0..7).
REQ-017 SHALL transition STOP->START with no idle gap if the holding register is full at STOP expiry, otherwise STOP->IDLE.
REQ-018 SHALL allow a new accept during START/DATA/STOP (double buffering) so back-to-back frames are seamless.
REQ-019 SHALL register oTx; it changes only on posedge, except on reset.
REQ-020 SHALL give a latency of 1 cycle: byte accepted at edge E in IDLE gives oTx falling at edge E+1; total frame 10*CLKS_PER_BIT cycles.
REQ-021 SHALL assert oBusy from entry to START through the last STOP cycle; oBusy=0 in IDLE.
REQ-022 SHALL size the bit-timer to ceil(log2(CLKS_PER_BIT)) bits with no wrap beyond CLKS_PER_BIT-1.

Reset
REQ-023 SHALL, while Reset=0, force immediately (asynchronously): state=IDLE, oTx=1, oReady=1, oBusy=0, holding register empty, timer=0, bit index=0, shift register=0.
REQ-024 SHALL abort a frame in progress on reset assertion mid-frame; the pending and holding bytes are discarded and not sent after release.
REQ-025 SHALL accept nothing while Reset=0; the first accept is possible on the first posedge after release.

Verification (CLKS_PER_BIT=4)
REQ-026 Bench SHALL check reset idle: Reset=0 then 1, iValid=0 for 50 cycles -> oTx=1, oReady=1, oBusy=0 throughout.
REQ-027 Bench SHALL check a single byte: 0xA5 accepted at edge E -> from E+1, oTx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles); oBusy high for those 40 cycles; then IDLE.
REQ-028 Bench SHALL check back-to-back frames: 0x01 then 0x80 offered continuously -> the 0x80 start bit immediately follows the 0x01 stop bit; 80 contiguous busy cycles; oReady low only while the holding register is full.
REQ-029 Bench SHALL check backpressure: three bytes 0x11, 0x22, 0x33 with iValid held -> 0x33 is accepted only after 0x22 enters the shift register; all three are transmitted in order and none are duplicated.
REQ-030 Bench SHALL check reset mid-frame: Reset=0 during DATA bit 3 of 0xFF -> oTx=1 immediately; after release no frame and oBusy=0 until a new accept.
REQ-031 Bench SHALL check an ignored strobe: iValid=1 with iData=0x5A on a cycle when oReady=0 -> 0x5A is never transmitted.
